// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- consumer-side bundle of the UART receiver.
//
// Signals
//   dout       [7:0]  last accepted byte
//   valid             dout holds an unconsumed byte
//   ack               consumer takes dout (only meaningful while valid=1)
//   frame_err         one-clk pulse: stop bit sampled 0
//   parity_err        one-clk pulse: parity mismatch (parity builds only)
//   overrun           one-clk pulse: byte completed while valid=1 and ack=0
//   busy              receiver is somewhere other than IDLE
//
// Modports
//   master  the receiver (drives data/status, reads ack)
//   slave   the consumer (reads data/status, drives ack)
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic [7:0] dout;
    logic       valid;
    logic       ack;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    modport master (
        output dout, valid, frame_err, parity_err, overrun, busy,
        input  ack
    );

    modport slave (
        input  dout, valid, frame_err, parity_err, overrun, busy,
        output ack
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling asynchronous serial receiver, 8 data bits, LSB first.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   sample_tick  one-clk enable at OVS x baud; all framing state advances
//                only on this enable
//   rx           raw serial line, idle high
//   bus          uart_rx_if.master: dout/valid/ack handshake plus the
//                frame_err / parity_err / overrun pulses and busy
//
// Parameter
//   OVS          sample_ticks per bit period (even, >= 8)
//
// Build option
//   UART_RX_PARITY_EN  when defined, an even-parity bit is expected after
//                      data bit 7; otherwise the frame is 8N1 and
//                      parity_err is held at 0.
//
// Each bit is the majority of the synchronized line at tick counts
// OVS/2-2, OVS/2-1 and OVS/2 within the bit; the decision is taken on the
// OVS/2 tick.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVS = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sample_tick,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int              CW      = $clog2(OVS);
    localparam logic [CW-1:0]   CNT_MAX = CW'(OVS - 1);
    localparam logic [CW-1:0]   MID     = CW'(OVS / 2);
    localparam logic [CW-1:0]   MID_M1  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0]   MID_M2  = CW'(OVS / 2 - 2);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // 2-of-3 vote used for every bit decision
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    // Parity bit value that makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic           rx_meta_r;
    logic           rx_sync_r;
    logic [1:0]     fill_r;
    logic           armed_r;
    state_t         state_r;
    state_t         state_nx;
    logic [CW-1:0]  tick_cnt_r;
    logic [CW-1:0]  cnt_nx;
    logic [2:0]     bit_cnt_r;
    logic [2:0]     bit_nx;
    logic [7:0]     shift_r;
    logic [7:0]     shift_nx;
    logic           samp0_r;
    logic           samp0_nx;
    logic           samp1_r;
    logic           samp1_nx;
    logic [7:0]     dout_r;
    logic           valid_r;
    logic           frame_err_r;
    logic           overrun_r;
    logic           busy_r;
    logic           deliver_s;
    logic           ferr_s;
    logic           counting_s;
    logic           mid_s;
    logic           maj_s;
`ifdef UART_RX_PARITY_EN
    logic           par_bit_r;
    logic           par_nx;
    logic           perr_s;
    logic           parity_err_r;
`endif

    // Two-flop synchronizer on the raw line; resets to the idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Arming: after reset the synchronizer still holds its reset value for
    // two clocks, and the line may be mid-frame. A start is only accepted
    // once a genuine high level has been seen, so a frame cut by reset is
    // never picked up half-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_r  <= 2'b00;
            armed_r <= 1'b0;
        end else begin
            fill_r  <= {fill_r[0], 1'b1};
            armed_r <= armed_r | (sample_tick & rx_sync_r & fill_r[1]);
        end
    end

    assign counting_s = (state_r != ST_IDLE) && (state_r != ST_BREAK);
    assign mid_s      = (tick_cnt_r == MID);
    assign maj_s      = majority3(samp0_r, samp1_r, rx_sync_r);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state, counters and per-tick datapath decisions
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = tick_cnt_r;
        bit_nx    = bit_cnt_r;
        shift_nx  = shift_r;
        samp0_nx  = samp0_r;
        samp1_nx  = samp1_r;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nx    = par_bit_r;
        perr_s    = 1'b0;
`endif
        if (sample_tick) begin
            // The tick counter free-runs modulo OVS inside a frame. After the
            // start-bit decision at OVS/2 it simply keeps counting, so every
            // later bit is decided exactly OVS ticks after the previous one.
            if (counting_s) begin
                if (tick_cnt_r == CNT_MAX) begin
                    cnt_nx = CNT_ZERO;
                end else begin
                    cnt_nx = tick_cnt_r + 1'b1;
                end
                if (tick_cnt_r == MID_M2) begin
                    samp0_nx = rx_sync_r;
                end else begin
                    samp0_nx = samp0_r;
                end
                if (tick_cnt_r == MID_M1) begin
                    samp1_nx = rx_sync_r;
                end else begin
                    samp1_nx = samp1_r;
                end
            end else begin
                cnt_nx = CNT_ZERO;
            end

            case (state_r)
                ST_IDLE: begin
                    if (armed_r && !rx_sync_r) begin
                        state_nx = ST_START;
                        cnt_nx   = CNT_ZERO;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (mid_s && maj_s) begin
                        // Too short to be a start bit
                        state_nx = ST_IDLE;
                        cnt_nx   = CNT_ZERO;
                    end else if (mid_s) begin
                        state_nx = ST_DATA;
                        bit_nx   = 3'd0;
                    end else begin
                        state_nx = ST_START;
                    end
                end
                ST_DATA: begin
                    if (mid_s) begin
                        shift_nx = {maj_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nx = ST_PARITY;
`else
                            state_nx = ST_STOP;
`endif
                            bit_nx   = 3'd0;
                        end else begin
                            bit_nx = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        state_nx = ST_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (mid_s) begin
                        par_nx   = maj_s;
                        state_nx = ST_STOP;
                    end else begin
                        state_nx = ST_PARITY;
                    end
                end
`endif
                ST_STOP: begin
                    if (mid_s) begin
                        // Return to IDLE at mid-stop so the next start edge
                        // can be caught even with zero idle time.
                        cnt_nx = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
                        perr_s = (par_bit_r != even_parity(shift_r));
`endif
                        if (maj_s) begin
                            state_nx  = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            deliver_s = ~perr_s;
`else
                            deliver_s = 1'b1;
`endif
                        end else begin
                            ferr_s   = 1'b1;
                            state_nx = ST_BREAK;
                        end
                    end else begin
                        state_nx = ST_STOP;
                    end
                end
                ST_BREAK: begin
                    if (rx_sync_r) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_BREAK;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = CNT_ZERO;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Frame datapath registers (counters, vote samples, shift register)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            samp0_r    <= 1'b1;
            samp1_r    <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            tick_cnt_r <= cnt_nx;
            bit_cnt_r  <= bit_nx;
            shift_r    <= shift_nx;
            samp0_r    <= samp0_nx;
            samp1_r    <= samp1_nx;
            busy_r     <= (state_nx != ST_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Received parity bit and its mismatch pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            par_bit_r    <= par_nx;
            parity_err_r <= perr_s;
        end
    end
`endif

    // Output handshake: load, hold-and-flag overrun, or consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r      <= 8'h00;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= ferr_s;
            overrun_r   <= 1'b0;
            if (deliver_s) begin
                if (!valid_r || bus.ack) begin
                    dout_r  <= shift_r;
                    valid_r <= 1'b1;
                end else begin
                    // Unconsumed byte wins; the new one is dropped
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && bus.ack) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign bus.dout      = dout_r;
    assign bus.valid     = valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;
    assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVS, default 16, meaning sample_tick pulses per bit period; legal values are even and at least 8.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sample_tick  input  1  one-clk enable at OVS x baud (from frac_div).
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8 data bits, LSB first.
REQ-006 SHALL have port dout  output  8  last accepted byte.
REQ-007 SHALL have port valid  output  1  dout holds an unconsumed byte.
REQ-008 SHALL have port ack  input  1  consumer takes dout; meaningful only while valid=1.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled 0.
REQ-010 SHALL have port parity_err  output  1  one-clk pulse: parity mismatch (see Configuration).
REQ-011 SHALL have port overrun  output  1  one-clk pulse: byte completed while valid=1 and ack=0.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass rx through a 2-FF synchronizer clocked every clk; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-015 SHALL keep a 0..OVS-1 tick counter advanced only on sample_tick, and a 3-bit bit counter.
REQ-016 SHALL form each bit value as the majority of the synchronized rx on the sample_ticks at counts OVS/2-2, OVS/2-1 and OVS/2; the decision is made at count OVS/2.
REQ-017 IDLE: on a sample_tick with synchronized rx=0, SHALL enter START with tick count 0.
REQ-018 START: a majority value of 1 SHALL return to IDLE (glitch reject, no outputs); 0 SHALL re-zero the phase to mid-bit and enter DATA.
REQ-019 DATA: SHALL shift each bit in LSB first, one per OVS ticks; after bit 7 SHALL enter STOP (or PARITY).
REQ-020 STOP, value 1: SHALL deliver the byte and enter IDLE at mid-stop, so back-to-back frames are received.
REQ-021 STOP, value 0: SHALL pulse frame_err, discard the byte, and enter BREAK.
REQ-022 BREAK: SHALL wait for synchronized rx=1 on a sample_tick, then enter IDLE.
REQ-023 Deliver with valid=0, or with valid=1 and ack=1 in the same clk: SHALL load dout in the next clk and leave valid=1.
REQ-024 Deliver with valid=1 and ack=0: SHALL keep dout unchanged, keep valid=1, pulse overrun, and drop the new byte.
REQ-025 ack with valid=1 and no deliver: SHALL clear valid in the next clk; ack with valid=0 SHALL be ignored.
REQ-026 Latency: SHALL assert valid exactly 1 clk after the mid-stop sample_tick.
REQ-027 sample_tick=0 SHALL freeze all state and counters; the synchronizer and the handshake still run.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, counters 0, synchronizer 11, dout 0x00, valid/frame_err/parity_err/overrun/busy 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for the next falling edge and deliver no partial byte.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: SHALL expect an even-parity bit after bit 7 (PARITY state, sampled as in REQ-016).
REQ-031 With the macro, a mismatch SHALL pulse parity_err in the stop-bit decision clk and discard the byte; the stop bit is still checked.
REQ-032 Macro undefined: SHALL have no PARITY state (8N1), and parity_err SHALL be tied to 0.

Verification
REQ-033 Bench setup SHALL use OVS=16, sample_tick every 4th clk, and 8N1 unless stated.
REQ-034 SHALL cover: frame 0x61 -> valid=1 with dout=0x61 exactly 1 clk after the mid-stop tick; ack -> valid=0 next clk.
REQ-035 SHALL cover: rx low for 5 ticks, then high -> return to IDLE, valid, frame_err and busy-end with no byte.
REQ-036 SHALL cover: frame 0x7A with stop bit 0, then line held low for 40 ticks -> one frame_err pulse, valid stays 0, busy stays 1 until rx goes high.
REQ-037 SHALL cover: 0x61 then 0x62 back-to-back with no ack -> dout=0x61, one overrun pulse; repeat with ack on the deliver clk -> dout=0x62, no overrun.
REQ-038 SHALL cover: rst_n low during bit 3 of 0x55, then a clean 0x41 -> only 0x41 delivered.
REQ-039 SHALL cover, with UART_RX_PARITY_EN: 0x03 with parity bit 1 -> parity_err pulse, no valid; 0x03 with parity bit 0 -> dout=0x03.
